// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port. A winning handshake appears on we3/A3/WD3 one cycle later.
// Backpressure: only the winner sees req_ready, and stall or reset drops all grants combinationally. x0 writes are acked, dropped and counted.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               we3,
  output logic [AW-1:0]      A3,
  output logic [DW-1:0]      WD3,
  output logic [2:0]         wr_src,
  output logic [15:0]        drop_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic          r_we3;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd3;
  logic [2:0]    r_src;
  logic [15:0]   r_drop;

  logic          w_found;
  logic [PW-1:0] w_win;
  logic          w_grant;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [PW-1:0] w_ptr_nxt;

  // Search starts at r_ptr and wraps; the first valid index wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_grant   = rst && !stall && w_found;
  assign w_addr    = req_addr[w_win*AW +: AW];
  assign w_data    = req_data[w_win*DW +: DW];
  assign w_ptr_nxt = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant && (w_win == PW'(i));
    end
  end

  // Idle or stalled cycles only clear we3; the captured write and pointer hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_we3  <= 1'b0;
      r_a3   <= '0;
      r_wd3  <= '0;
      r_src  <= '0;
      r_drop <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
      r_a3  <= w_addr;
      r_wd3 <= w_data;
      r_src <= 3'(w_win);
      r_we3 <= (w_addr != '0);
      if ((w_addr == '0) && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign we3      = r_we3;
  assign A3       = r_a3;
  assign WD3      = r_wd3;
  assign wr_src   = r_src;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, hand sequences for reset and saturation, then random traffic against a reference model.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               we3;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD3;
  logic [2:0]         wr_src;
  logic [15:0]        drop_cnt;

  int total = 0;
  int bad   = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .we3(we3), .A3(A3), .WD3(WD3), .wr_src(wr_src), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 pre_reset;
    logic [NREQ-1:0]    v;
    logic               st;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    e_rdy;
    logic               e_we;
    logic [AW-1:0]      e_a3;
    logic [DW-1:0]      e_wd;
    logic [2:0]         e_src;
    logic [15:0]        e_drop;
  } vec_t;

  vec_t tbl[$];

  // Reference model: arbitration pointer plus the architectural output state.
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  logic [2:0]  m_src;
  int          m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit pr, input logic [2:0] v, input logic st,
                              input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] rdy, input logic we, input logic [4:0] a3,
                              input logic [31:0] wd, input logic [2:0] src, input logic [15:0] drp);
    vec_t r;
    r.pre_reset = pr; r.v = v; r.st = st; r.a = a; r.d = d;
    r.e_rdy = rdy; r.e_we = we; r.e_a3 = a3; r.e_wd = wd; r.e_src = src; r.e_drop = drp;
    return r;
  endfunction

  // Called at posedge+1: drive, check ready mid-cycle, then check registered outputs after the edge.
  task automatic step(input logic [2:0] v, input logic st, input logic [14:0] a, input logic [95:0] d,
                      input logic [2:0] e_rdy, input logic e_we, input logic [4:0] e_a3,
                      input logic [31:0] e_wd, input logic [2:0] e_src, input logic [15:0] e_drop);
    req_valid = v; stall = st; req_addr = a; req_data = d;
    #2;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    @(posedge clk);
    #1;
    chk("we3", 64'(we3), 64'(e_we));
    chk("A3", 64'(A3), 64'(e_a3));
    chk("WD3", 64'(WD3), 64'(e_wd));
    chk("wr_src", 64'(wr_src), 64'(e_src));
    chk("drop_cnt", 64'(drop_cnt), 64'(e_drop));
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd = '0; m_src = '0; m_drop = 0;
  endtask

  function automatic int m_pick(input logic [2:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  logic [14:0] ac, a1, a2, a4, a7, ar;
  logic [95:0] dc, d1, d2, d4, d7, dr;
  logic [NREQ-1:0] pend;
  logic [4:0]  pa [NREQ];
  logic [31:0] pd [NREQ];

  initial begin
    ac = {5'd3, 5'd2, 5'd1};  dc = {32'h102, 32'h101, 32'h100};
    a1 = {5'd0, 5'd5, 5'd0};  d1 = {32'h0, 32'hDEADBEEF, 32'h0};
    a2 = {5'd0, 5'd0, 5'd0};  d2 = {32'h55, 32'h0, 32'h0};
    a4 = {5'd3, 5'd2, 5'd4};  d4 = {32'h102, 32'h101, 32'h44};
    a7 = {5'd0, 5'd0, 5'd7};  d7 = {32'h0, 32'h0, 32'h77};

    // Single requester, then an idle cycle.
    tbl.push_back(mk(1, 3'b010, 0, a1, d1, 3'b010, 1, 5'd5, 32'hDEADBEEF, 3'd1, 16'd0));
    tbl.push_back(mk(0, 3'b000, 0, a1, d1, 3'b000, 0, 5'd5, 32'hDEADBEEF, 3'd1, 16'd0));
    // Full contention rotates 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(i == 0, 3'b111, 0, ac, dc, 3'(1 << (i % 3)), 1, 5'((i % 3) + 1),
                       32'(32'h100 + i % 3), 3'(i % 3), 16'd0));
    // Idle gaps: pointer only moves on grants (ends at 2, so the full request goes to 2).
    tbl.push_back(mk(0, 3'b010, 0, ac, dc, 3'b010, 1, 5'd2, 32'h101, 3'd1, 16'd0));
    tbl.push_back(mk(0, 3'b000, 0, ac, dc, 3'b000, 0, 5'd2, 32'h101, 3'd1, 16'd0));
    tbl.push_back(mk(0, 3'b010, 0, ac, dc, 3'b010, 1, 5'd2, 32'h101, 3'd1, 16'd0));
    tbl.push_back(mk(0, 3'b000, 0, ac, dc, 3'b000, 0, 5'd2, 32'h101, 3'd1, 16'd0));
    tbl.push_back(mk(0, 3'b111, 0, ac, dc, 3'b100, 1, 5'd3, 32'h102, 3'd2, 16'd0));
    // x0 write is acked but discarded.
    tbl.push_back(mk(1, 3'b100, 0, a2, d2, 3'b100, 0, 5'd0, 32'h55, 3'd2, 16'd1));
    // Stall holds the pointer; first grant after it goes to requester 1.
    tbl.push_back(mk(1, 3'b001, 0, a4, d4, 3'b001, 1, 5'd4, 32'h44, 3'd0, 16'd0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 3'b111, 1, a4, d4, 3'b000, 0, 5'd4, 32'h44, 3'd0, 16'd0));
    tbl.push_back(mk(0, 3'b111, 0, a4, d4, 3'b010, 1, 5'd2, 32'h101, 3'd1, 16'd0));

    // Reset state: ready stays low even with all requesters valid.
    rst = 1'b0; stall = 1'b0; req_valid = 3'b111; req_addr = ac; req_data = dc;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_A3", 64'(A3), 64'd0);
    chk("rst_WD3", 64'(WD3), 64'd0);
    chk("rst_src", 64'(wr_src), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = '0;

    foreach (tbl[i]) begin
      if (tbl[i].pre_reset) do_reset();
      step(tbl[i].v, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].e_rdy, tbl[i].e_we,
           tbl[i].e_a3, tbl[i].e_wd, tbl[i].e_src, tbl[i].e_drop);
    end

    // Reset mid-operation discards the pending write and the drop count.
    do_reset();
    step(3'b100, 0, a2, d2, 3'b100, 0, 5'd0, 32'h55, 3'd2, 16'd1);
    step(3'b001, 0, a7, d7, 3'b001, 1, 5'd7, 32'h77, 3'd0, 16'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_we3", 64'(we3), 64'd0);
    chk("mid_rst_A3", 64'(A3), 64'd0);
    chk("mid_rst_WD3", 64'(WD3), 64'd0);
    chk("mid_rst_src", 64'(wr_src), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    req_valid = 3'b101; req_addr = {5'd9, 5'd0, 5'd8}; req_data = {32'h99, 32'h0, 32'h88};
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    chk("post_rst_A3", 64'(A3), 64'd8);
    chk("post_rst_src", 64'(wr_src), 64'd0);

    // Drop counter saturation.
    do_reset();
    req_valid = 3'b111; req_addr = a2; req_data = d2;
    repeat (65534) @(posedge clk);
    #1;
    chk("drop_fffe", 64'(drop_cnt), 64'hFFFE);
    @(posedge clk);
    #1;
    chk("drop_ffff", 64'(drop_cnt), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_sat", 64'(drop_cnt), 64'hFFFF);

    // Random traffic with requesters holding their request until granted.
    do_reset();
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      logic [2:0] v;
      logic       st;
      logic [2:0] e_rdy;
      int         w;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i] = $urandom;
        end
      end
      v = pend;
      st = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NREQ; i++) begin
        ar[i*AW +: AW] = pa[i];
        dr[i*DW +: DW] = pd[i];
      end
      w = m_pick(v);
      e_rdy = '0;
      if (!st && w >= 0) begin
        e_rdy = 3'(1 << w);
        m_ptr = (w + 1) % NREQ;
        m_a3 = pa[w]; m_wd = pd[w]; m_src = 3'(w);
        m_we = (pa[w] != 5'd0);
        if (pa[w] == 5'd0 && m_drop < 65535) m_drop++;
      end else begin
        m_we = 1'b0;
      end
      step(v, st, ar, dr, e_rdy, m_we, m_a3, m_wd, m_src, 16'(m_drop));
      if (!st && w >= 0) pend[w] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
